fir_mac_sequencer: RTL

// - Read-side controller for the 64-tap, 16-bit FIR filter. Pops one sample per output from the sample FIFO.
// - Keeps the sample history in a circular delay line.
// - Runs one shared signed 16x16 multiplier-accumulator over all taps against an external coefficient store.
// - Presents each filtered sample on a valid/ready output port. Sits between the FIFO read port and the output stage.

---
 rtl/fir_mac_sequencer.sv | 101 ++++++++++
 1 files changed

// File: rtl/fir_mac_sequencer.sv
// Read-side FIR controller: pops one sample, runs a shared MAC over TAPS taps, then presents y[n] on valid/ready.
// Optional output saturation is built when FIR_SEQ_SAT_EN is defined; otherwise y is two's-complement wrapped.
module fir_mac_sequencer #(
    parameter int TAPS      = 64,
    parameter int DW        = 16,
    parameter int AW        = 6,
    parameter int OUT_SHIFT = 15
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          fifo_empty,
    output logic          fifo_rd,
    input  logic [DW-1:0] fifo_rdata,
    output logic [AW-1:0] coef_addr,
    input  logic [DW-1:0] coef_data,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_MAC   = 3'd3;
    localparam logic [2:0] S_OUT   = 3'd4;
    localparam int ACCW = 2*DW + AW;

    logic [2:0]               state;
    logic [AW-1:0]            wr_ptr;
    logic [AW-1:0]            k;
    logic [AW-1:0]            rd_idx;
    logic signed [DW-1:0]     dline [TAPS];
    logic signed [DW-1:0]     x_tap;
    logic signed [2*DW-1:0]   prod;
    logic signed [ACCW-1:0]   acc;
    logic signed [ACCW-1:0]   acc_nxt;
    logic [DW-1:0]            y_out;

    // wr_ptr points at the newest sample while MAC runs, so k walks back in time.
    assign rd_idx  = wr_ptr - k;
    assign x_tap   = dline[rd_idx];
    assign prod    = (2*DW)'($signed(coef_data)) * (2*DW)'(x_tap);
    assign acc_nxt = acc + ACCW'(prod);

`ifdef FIR_SEQ_SAT_EN
    localparam logic signed [ACCW-1:0] Y_MAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] Y_MIN = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};
    logic signed [ACCW-1:0] y_full;

    assign y_full = acc_nxt >>> OUT_SHIFT;

    always_comb begin
        y_out = y_full[DW-1:0];
        if (y_full > Y_MAX)
            y_out = Y_MAX[DW-1:0];
        else if (y_full < Y_MIN)
            y_out = Y_MIN[DW-1:0];
    end
`else
    assign y_out = DW'(acc_nxt >>> OUT_SHIFT);
`endif

    assign fifo_rd   = (state == S_FETCH) && !fifo_empty;
    assign coef_addr = (state == S_MAC) ? k : '0;
    assign out_valid = (state == S_OUT);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= S_IDLE;
            wr_ptr   <= '0;
            k        <= '0;
            acc      <= '0;
            out_data <= '0;
            for (int i = 0; i < TAPS; i++)
                dline[i] <= '0;
        end else begin
            case (state)
                S_IDLE:  state <= S_FETCH;
                S_FETCH: if (!fifo_empty) state <= S_LOAD;
                S_LOAD: begin
                    dline[wr_ptr] <= $signed(fifo_rdata);
                    acc           <= '0;
                    k             <= '0;
                    state         <= S_MAC;
                end
                S_MAC: begin
                    acc <= acc_nxt;
                    k   <= k + AW'(1);
                    if (k == AW'(TAPS-1)) begin
                        wr_ptr   <= wr_ptr + AW'(1);
                        out_data <= y_out;
                        state    <= S_OUT;
                    end
                end
                S_OUT:   if (out_ready) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
